// File: rtl/pixel_pkg.sv
// Shared types and default parameters for the pixel merger and its per-core FIFOs.
package pixel_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } merger_state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam int DEF_NUM_CORES  = 4;
    localparam int DEF_PIX_W      = 24;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_DIM_W      = 13;

endpackage

// File: rtl/pixel_merger_if.sv
// Core-side input channels and AXI4-Stream video output of the pixel merger.
interface pixel_merger_if
    import pixel_pkg::*;
#(
    parameter int NUM_CORES = DEF_NUM_CORES,
    parameter int PIX_W     = DEF_PIX_W
) ();

    logic [NUM_CORES*PIX_W-1:0] core_data;
    logic [NUM_CORES-1:0]       core_valid;
    logic [NUM_CORES-1:0]       core_ready;
    logic [PIX_W-1:0]           m_tdata;
    logic                       m_tvalid;
    logic                       m_tready;
    logic                       m_tuser;
    logic                       m_tlast;

    // The merger is the stream master on the video side.
    modport master (
        input  core_data, core_valid, m_tready,
        output core_ready, m_tdata, m_tvalid, m_tuser, m_tlast
    );

    modport slave (
        output core_data, core_valid, m_tready,
        input  core_ready, m_tdata, m_tvalid, m_tuser, m_tlast
    );

endinterface

// File: rtl/pixel_fifo.sv
// Small synchronous FIFO with a combinational head read; one instance per compute core.
module pixel_fifo
    import pixel_pkg::*;
#(
    parameter int WIDTH = DEF_PIX_W,
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = DEPTH[CNT_W-1:0];

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push, do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Power-of-two depth lets the pointers wrap naturally at their width.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        if (do_push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/pixel_merger.sv
// Merges per-core pixel streams in strict round-robin order into one AXI4-Stream video output
// with SOF/EOL markers generated from internal x/y counters.
module pixel_merger
    import pixel_pkg::*;
#(
    parameter int NUM_CORES  = DEF_NUM_CORES,
    parameter int PIX_W      = DEF_PIX_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int DIM_W      = DEF_DIM_W
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    pixel_merger_if.master               bus,
    input  logic [$clog2(NUM_CORES)-1:0] active_cores,
    input  logic [DIM_W-1:0]             image_width,
    input  logic [DIM_W-1:0]             image_height,
    output logic                         frame_done
);

    localparam int CUR_W = $clog2(NUM_CORES);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    merger_state_t    state_q, state_d;
    logic [CUR_W-1:0] cur_q, cur_d, ac_q, ac_d;
    logic [DIM_W-1:0] w_q, w_d, h_q, h_d, x_q, x_d, y_q, y_d;
    logic [PIX_W-1:0] tdata_q, tdata_d;
    logic             tvalid_q, tvalid_d, tuser_q, tuser_d, tlast_q, tlast_d;
    logic             flast_q, flast_d, frame_done_q, frame_done_d;

    logic [NUM_CORES-1:0] fifo_full, fifo_empty, fifo_pop, core_en, core_ready;
    logic [PIX_W-1:0]     fifo_dout [NUM_CORES];
    logic [CNT_W-1:0]     fill_unused [NUM_CORES];
    logic                 dims_ok, accept, frame_end, load;

    assign dims_ok   = (w_q != '0) && (h_q != '0);
    assign accept    = tvalid_q && bus.m_tready;
    assign frame_end = accept && flast_q;
    // Strictly in-order: only the FIFO under the pointer may feed the output register.
    assign load      = !fifo_empty[cur_q] && dims_ok && (!tvalid_q || accept) && !frame_end;

    always_comb begin
        core_en = '0;
        for (int i = 0; i < NUM_CORES; i++) core_en[i] = (i <= int'(ac_q));
    end

    for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
        assign core_ready[i] = dims_ok && core_en[i] && !fifo_full[i];
        assign fifo_pop[i]   = load && (cur_q == CUR_W'(i));

        pixel_fifo #(
            .WIDTH (PIX_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (aclk),
            .rst_n (aresetn),
            .push  (bus.core_valid[i] && core_ready[i]),
            .pop   (fifo_pop[i]),
            .din   (bus.core_data[i*PIX_W +: PIX_W]),
            .dout  (fifo_dout[i]),
            .full  (fifo_full[i]),
            .empty (fifo_empty[i]),
            .count (fill_unused[i])
        );
    end

    always_comb begin
        state_d      = state_q;
        cur_d        = cur_q;
        ac_d         = ac_q;
        w_d          = w_q;
        h_d          = h_q;
        x_d          = x_q;
        y_d          = y_q;
        tdata_d      = tdata_q;
        tvalid_d     = tvalid_q;
        tuser_d      = tuser_q;
        tlast_d      = tlast_q;
        flast_d      = flast_q;
        frame_done_d = 1'b0;

        if (state_q == IDLE) begin
            w_d  = image_width;
            h_d  = image_height;
            ac_d = active_cores;
        end

        if (accept) tvalid_d = 1'b0;

        // Markers are decided from the coordinates of the pixel being loaded.
        if (load) begin
            tdata_d  = fifo_dout[cur_q];
            tvalid_d = 1'b1;
            tuser_d  = (x_q == '0) && (y_q == '0);
            tlast_d  = (x_q == w_q - DIM_W'(1));
            flast_d  = tlast_d && (y_q == h_q - DIM_W'(1));
            cur_d    = (cur_q == ac_q) ? '0 : cur_q + CUR_W'(1);
            if (tlast_d) begin
                x_d = '0;
                y_d = (y_q == h_q - DIM_W'(1)) ? '0 : y_q + DIM_W'(1);
            end else begin
                x_d = x_q + DIM_W'(1);
            end
            if (state_q == IDLE) state_d = STREAM;
        end

        if (frame_end) begin
            state_d      = IDLE;
            cur_d        = '0;
            x_d          = '0;
            y_d          = '0;
            frame_done_d = 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= IDLE;
            cur_q        <= '0;
            ac_q         <= '0;
            w_q          <= '0;
            h_q          <= '0;
            x_q          <= '0;
            y_q          <= '0;
            tdata_q      <= '0;
            tvalid_q     <= 1'b0;
            tuser_q      <= 1'b0;
            tlast_q      <= 1'b0;
            flast_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            ac_q         <= ac_d;
            w_q          <= w_d;
            h_q          <= h_d;
            x_q          <= x_d;
            y_q          <= y_d;
            tdata_q      <= tdata_d;
            tvalid_q     <= tvalid_d;
            tuser_q      <= tuser_d;
            tlast_q      <= tlast_d;
            flast_q      <= flast_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.core_ready = core_ready;
    assign bus.m_tdata    = tdata_q;
    assign bus.m_tvalid   = tvalid_q;
    assign bus.m_tuser    = tuser_q;
    assign bus.m_tlast    = tlast_q;
    assign frame_done     = frame_done_q;

endmodule
